stepper_ramp_drive: RTL and testbench
=====================================

# stepper_ramp_drive

Parametrised multi-channel unipolar stepper driver: the successor to the fixed 200 Hz, two-motor stepping path in the maze car.
- Replaces the divided "speed" clock with per-channel clock-enable timers, so all logic runs on the single system clock.
- Adds linear acceleration and deceleration ramps, full-step and half-step phase modes, and a direction latch held for the duration of each move.
- Sits between the navigation logic and the coil drivers: one run/dir pair in per motor, one 4-bit coil word out per motor.

## Interface
- NUM_CH, 2: number of independent motor channels.
- DIV_W, 20: width of the period register and step timer; must hold PERIOD_START.
- PERIOD_START, 1000000: step interval in clk cycles at standstill (100 Hz at 100 MHz).
- PERIOD_MIN, 250000: cruise step interval (400 Hz); ≥2 and ≤PERIOD_START.
- RAMP_DEC, 5000: period change applied per step while ramping; ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- run  in  NUM_CH  per channel; 1 = move, 0 = ramp down and stop.
- dir  in  NUM_CH  per channel; 1 = forward (index +), 0 = reverse; latched only when leaving IDLE.
- half_step  in  1  global mode; 1 = 8-state half-step, 0 = 4-state two-phase full-step; sampled at every step.
- coils  out  4*NUM_CH  channel n uses bits [4n+3:4n], order {A,B,C,D}.
- step_pulse  out  NUM_CH  1-cycle strobe on each phase advance.
- busy  out  NUM_CH  channel state ≠ IDLE.
- at_speed  out  NUM_CH  channel state = CRUISE.

## Operation
- Channels are fully independent replicated instances. Per-channel registers:
  - state
  - idx[2:0] (phase index)
  - cnt[DIV_W-1:0]
  - period[DIV_W-1:0]
  - dir_l
- Phase table, idx to {A,B,C,D}: 0 → 1000, 1 → 1100, 2 → 0100, 3 → 0110, 4 → 0010, 5 → 0011, 6 → 0001, 7 → 1001.
- coils = table[idx] when state ≠ IDLE, else 0000. Coils are a pure decode of registered state, so the driver de-energises when idle.
- Step tick: cnt == period-1. On a tick, cnt is cleared; otherwise cnt increments.
- Phase advance on each step: delta = 1 if half_step, else (idx odd ? 2 : 1). The first full-step from an even index therefore realigns to an odd, two-coil state.
- idx moves +delta if dir_l, else −delta, modulo 8 (wraps 7 → 0 and 0 → 7).
- FSM, per channel:
  - IDLE: when run = 1, set period = PERIOD_START, cnt = 0, dir_l = dir → ACCEL. idx is retained from the last move.
  - ACCEL: on each step, period = max(period − RAMP_DEC, PERIOD_MIN). If the result equals PERIOD_MIN → CRUISE. If run = 0 (checked every cycle) → DECEL with period and cnt untouched.
  - CRUISE: step at PERIOD_MIN. If run = 0 → DECEL.
  - DECEL: on each step, period = min(period + RAMP_DEC, PERIOD_START). If the result equals PERIOD_START → IDLE. If run = 1 → ACCEL from the current period.
- Arithmetic: saturating compare is done before the subtract/add, so no underflow or overflow within DIV_W.
- A dir change while busy is ignored until the next IDLE exit.
- A half_step change takes effect on the next step in any state.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, idx = 0, cnt = 0, period = PERIOD_START, all outputs 0.
  - Mid-move, coils drop to 0 immediately without waiting for clk.
  - Release is synchronous to the next clk edge.
- run sampled high at edge E: busy = 1 and coils = table[idx] from edge E. The first step_pulse occurs at edge E + PERIOD_START.
- step_pulse, the idx update, the coil change and the period update all happen on the same edge. A new period governs the following interval.
- Transition into IDLE from DECEL happens on the final step edge: that step's coils are never driven, and coils = 0000 from that edge.
- run falling is seen within 1 cycle. The in-progress interval completes at its current period.
- Period sequence for a full move with no interruptions: PERIOD_START, PERIOD_START − RAMP_DEC, …, PERIOD_MIN (cruise), then symmetric back up.

## Test plan
- Parameters for the bench: NUM_CH=2, PERIOD_START=8, PERIOD_MIN=4, RAMP_DEC=2, DIV_W=4.
- Accel/cruise/decel: ch0 run=1, dir=1, half_step=1.
  - Step intervals must be 8, 6, 4, 4…; at_speed rises on the 2nd step; coils 1100, 0100, 0110…
  - Drop run: remaining intervals 4 (period becomes 6), then 6 (period becomes 8, IDLE); busy = 0, coils = 0000.
- Full-step realign: from idx = 0, half_step=0, dir=1. idx must go 1, 3, 5, 7, 1; coils 1100, 0110, 0011, 1001, 1100.
- Reverse and wrap: dir=0, half_step=1, from idx = 0. idx must go 7, 6, 5; coils 1001, 0001, 0011. A dir toggle mid-move must not alter the direction.
- Run re-assert during DECEL: at period 6, run → 1. The next interval is 6, then 4 with CRUISE; no IDLE pass (busy stays 1).
- Async reset mid-CRUISE: pulse rst low between edges. coils, busy and step_pulse must be 0 before the next edge; after release with run held high, the first step comes at 8 cycles and idx restarts from 0.
- Channel independence: ch1 idle while ch0 runs. coils[7:4] must stay 0000 and step_pulse[1] must stay 0.

Source files
------------

// File: rtl/stepper_ramp_drive.sv
// Multi-channel unipolar stepper driver with linear accel/decel ramps.
// Each channel is an independent timer + ramp FSM producing a 4-bit coil word.

module stepper_ramp_ch #(
  parameter int DIV_W        = 20,
  parameter int PERIOD_START = 1000000,
  parameter int PERIOD_MIN   = 250000,
  parameter int RAMP_DEC     = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       dir_i,
  input  logic       half_step_i,
  output logic [3:0] coils_o,
  output logic       step_pulse_o,
  output logic       busy_o,
  output logic       at_speed_o
);
  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_e;

  localparam logic [DIV_W-1:0] P_START = DIV_W'(PERIOD_START);
  localparam logic [DIV_W-1:0] P_MIN   = DIV_W'(PERIOD_MIN);
  localparam logic [DIV_W-1:0] P_RAMP  = DIV_W'(RAMP_DEC);
  localparam logic [DIV_W-1:0] P_ONE   = DIV_W'(1);

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic               dir_q, dir_d;
  logic               pulse_q, pulse_d;

  logic               tick;
  logic [2:0]         delta, idx_step;
  logic [DIV_W-1:0]   dec_per, inc_per;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      period_q <= P_START;
      dir_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      pulse_q  <= pulse_d;
    end
  end

  // Saturation is decided by comparing the headroom first, so neither side wraps.
  assign tick     = (state_q != IDLE) && (cnt_q == period_q - P_ONE);
  assign delta    = (!half_step_i && idx_q[0]) ? 3'd2 : 3'd1;
  assign idx_step = dir_q ? idx_q + delta : idx_q - delta;
  assign dec_per  = (period_q - P_MIN <= P_RAMP) ? P_MIN : period_q - P_RAMP;
  assign inc_per  = (P_START - period_q <= P_RAMP) ? P_START : period_q + P_RAMP;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    dir_d    = dir_q;
    pulse_d  = 1'b0;
    if (state_q == IDLE) begin
      if (run_i) begin
        state_d  = ACCEL;
        period_d = P_START;
        cnt_d    = '0;
        dir_d    = dir_i;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + P_ONE;
      if (tick) begin
        idx_d   = idx_step;
        pulse_d = 1'b1;
      end
      // A run change wins over the ramp update; the interval itself still completes.
      case (state_q)
        ACCEL: begin
          if (!run_i) state_d = DECEL;
          else if (tick) begin
            period_d = dec_per;
            if (dec_per == P_MIN) state_d = CRUISE;
          end
        end
        CRUISE: if (!run_i) state_d = DECEL;
        DECEL: begin
          if (run_i) state_d = ACCEL;
          else if (tick) begin
            period_d = inc_per;
            if (inc_per == P_START) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    coils_o = 4'b0000;
    if (state_q != IDLE) begin
      case (idx_q)
        3'd0: coils_o = 4'b1000;
        3'd1: coils_o = 4'b1100;
        3'd2: coils_o = 4'b0100;
        3'd3: coils_o = 4'b0110;
        3'd4: coils_o = 4'b0010;
        3'd5: coils_o = 4'b0011;
        3'd6: coils_o = 4'b0001;
        default: coils_o = 4'b1001;
      endcase
    end
    busy_o       = (state_q != IDLE);
    at_speed_o   = (state_q == CRUISE);
    step_pulse_o = pulse_q;
  end
endmodule

module stepper_ramp_drive #(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = 20,
  parameter int PERIOD_START = 1000000,
  parameter int PERIOD_MIN   = 250000,
  parameter int RAMP_DEC     = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   run,
  input  logic [NUM_CH-1:0]   dir,
  input  logic                half_step,
  output logic [4*NUM_CH-1:0] coils,
  output logic [NUM_CH-1:0]   step_pulse,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   at_speed
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stepper_ramp_ch #(
      .DIV_W(DIV_W), .PERIOD_START(PERIOD_START),
      .PERIOD_MIN(PERIOD_MIN), .RAMP_DEC(RAMP_DEC)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst),
      .run_i        (run[g]),
      .dir_i        (dir[g]),
      .half_step_i  (half_step),
      .coils_o      (coils[4*g +: 4]),
      .step_pulse_o (step_pulse[g]),
      .busy_o       (busy[g]),
      .at_speed_o   (at_speed[g])
    );
  end
endmodule

// File: tb/tb_stepper_ramp_drive.sv
// Self-checking bench: directed ramp scenarios plus random run/dir/mode traffic,
// scored against an event-level model of step timing and phase sequence.

module tb_stepper_ramp_drive;
  localparam int NCH = 2, PS = 8, PM = 4, RD = 2;
  localparam int M_ACC = 0, M_CRU = 1, M_DEC = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] run = '0;
  logic [NCH-1:0] dir = '0;
  logic           half_step = 1'b0;
  logic [4*NCH-1:0] coils;
  logic [NCH-1:0] step_pulse, busy, at_speed;

  stepper_ramp_drive #(.NUM_CH(NCH), .DIV_W(4), .PERIOD_START(PS),
                       .PERIOD_MIN(PM), .RAMP_DEC(RD)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .half_step(half_step),
    .coils(coils), .step_pulse(step_pulse), .busy(busy), .at_speed(at_speed));

  always #5 clk = ~clk;

  typedef struct {int ch; int coils; int bsy; int spd;} exp_t;
  exp_t sq[$];

  logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int checks = 0, errors = 0, cyc = 0;
  int m_act [NCH] = '{0, 0};
  int m_mode[NCH] = '{0, 0};
  int m_idx [NCH] = '{0, 0};
  int m_el  [NCH] = '{0, 0};
  int m_per [NCH] = '{PS, PS};
  int m_fwd [NCH] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_coils(input int c);
    return m_act[c] ? int'(TBL[m_idx[c]]) : 0;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Reference model: tracks elapsed cycles against the current step interval.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_act[c] = 0; m_mode[c] = M_ACC; m_idx[c] = 0; m_el[c] = 0; m_per[c] = PS;
      end
      sq.delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_act[c] == 0) begin
          if (run[c]) begin
            m_act[c] = 1; m_mode[c] = M_ACC; m_per[c] = PS; m_el[c] = 0; m_fwd[c] = int'(dir[c]);
          end
        end else begin
          int sw, d;
          sw = 0;
          if (m_mode[c] != M_DEC && !run[c]) begin m_mode[c] = M_DEC; sw = 1; end
          else if (m_mode[c] == M_DEC && run[c]) begin m_mode[c] = M_ACC; sw = 1; end
          m_el[c]++;
          if (m_el[c] == m_per[c]) begin
            m_el[c] = 0;
            d = (half_step || (m_idx[c] % 2 == 0)) ? 1 : 2;
            m_idx[c] = m_fwd[c] != 0 ? (m_idx[c] + d) % 8 : (m_idx[c] + 8 - d) % 8;
            if (sw == 0) begin
              if (m_mode[c] == M_ACC) begin
                m_per[c] = (m_per[c] - RD < PM) ? PM : m_per[c] - RD;
                if (m_per[c] == PM) m_mode[c] = M_CRU;
              end else if (m_mode[c] == M_DEC) begin
                m_per[c] = (m_per[c] + RD > PS) ? PS : m_per[c] + RD;
                if (m_per[c] == PS) m_act[c] = 0;
              end
            end
            sq.push_back('{c, m_coils(c), m_act[c],
                           (m_act[c] != 0 && m_mode[c] == M_CRU) ? 1 : 0});
          end
        end
      end
    end
  end

  // Monitor: pops an expected step for every observed step_pulse.
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (step_pulse[c]) begin
        if (sq.size() > 0 && sq[0].ch == c) begin
          exp_t e;
          e = sq.pop_front();
          chk($sformatf("step_coils[%0d]", c), int'(coils[4*c +: 4]), e.coils);
          chk($sformatf("step_busy[%0d]", c), int'(busy[c]), e.bsy);
          chk($sformatf("step_at_speed[%0d]", c), int'(at_speed[c]), e.spd);
        end else chk($sformatf("unexpected_step[%0d]", c), 1, 0);
      end
    end
    if (sq.size() > 0) begin
      chk($sformatf("missed_step[%0d]", sq[0].ch), 0, 1);
      sq.delete();
    end
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("coils[%0d]", c), int'(coils[4*c +: 4]), m_coils(c));
      chk($sformatf("busy[%0d]", c), int'(busy[c]), m_act[c]);
      chk($sformatf("at_speed[%0d]", c), int'(at_speed[c]),
          (m_act[c] != 0 && m_mode[c] == M_CRU) ? 1 : 0);
    end
  end

  task automatic wait_pulse(input int c, output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step_pulse[c]) begin at = cyc; return; end
    end
    chk($sformatf("pulse_timeout[%0d]", c), 0, 1);
  endtask

  task automatic wait_idle(input int c);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy[c]) return;
    end
    chk($sformatf("idle_timeout[%0d]", c), 0, 1);
  endtask

  // Pulses reset between edges and checks outputs drop before the next edge.
  task automatic reset_pulse();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_coils", int'(coils), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pulse", int'(step_pulse), 0);
    chk("rst_at_speed", int'(at_speed), 0);
    #1 rst = 1'b1;
  endtask

  task automatic step_chk(input string nm, input int c, input int prev, input int gap,
                          input int cw, output int t);
    wait_pulse(c, t);
    chk({nm, "_gap"}, t - prev, gap);
    chk({nm, "_coils"}, int'(coils[4*c +: 4]), cw);
  endtask

  initial begin
    int t, t0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_coils", int'(coils), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulse", int'(step_pulse), 0);

    // Accel / cruise / decel on ch0, ch1 stays idle.
    half_step = 1'b1; dir[0] = 1'b1; run[0] = 1'b1; t0 = cyc + 1;
    step_chk("acc1", 0, t0, 8, 4'b1100, t);
    chk("acc1_at_speed", int'(at_speed[0]), 0);
    t0 = t; step_chk("acc2", 0, t0, 6, 4'b0100, t);
    chk("acc2_at_speed", int'(at_speed[0]), 1);
    t0 = t; step_chk("cru1", 0, t0, 4, 4'b0110, t);
    t0 = t; step_chk("cru2", 0, t0, 4, 4'b0010, t);
    chk("ch1_coils", int'(coils[7:4]), 0);
    chk("ch1_pulse", int'(step_pulse[1]), 0);
    run[0] = 1'b0;
    t0 = t; step_chk("dec1", 0, t0, 4, 4'b0011, t);
    t0 = t; step_chk("dec2", 0, t0, 6, 4'b0000, t);
    chk("dec2_busy", int'(busy[0]), 0);

    // Full-step realign from idx 0.
    reset_pulse();
    half_step = 1'b0; dir[0] = 1'b1; run[0] = 1'b1;
    @(negedge clk);
    foreach (TBL[i]) if (i < 5) begin
      int exp_idx;
      exp_idx = (2 * i + 1) % 8;
      wait_pulse(0, t);
      chk($sformatf("full_step%0d", i), int'(coils[3:0]), int'(TBL[exp_idx]));
    end
    run[0] = 1'b0; wait_idle(0);

    // Reverse with wrap; dir toggle mid-move is ignored.
    reset_pulse();
    half_step = 1'b1; dir[0] = 1'b0; run[0] = 1'b1;
    wait_pulse(0, t); chk("rev1", int'(coils[3:0]), 4'b1001);
    dir[0] = 1'b1;
    wait_pulse(0, t); chk("rev2", int'(coils[3:0]), 4'b0001);
    wait_pulse(0, t); chk("rev3", int'(coils[3:0]), 4'b0011);
    run[0] = 1'b0; wait_idle(0);

    // Run re-asserted during decel resumes accel without an idle pass.
    dir[0] = 1'b1; run[0] = 1'b1; t0 = cyc + 1;
    wait_pulse(0, t); chk("ra_gap1", t - t0, 8); t0 = t;
    wait_pulse(0, t); chk("ra_gap2", t - t0, 6); t0 = t;
    wait_pulse(0, t); chk("ra_gap3", t - t0, 4); t0 = t;
    run[0] = 1'b0;
    wait_pulse(0, t); chk("ra_dec_gap", t - t0, 4); t0 = t;
    run[0] = 1'b1;
    wait_pulse(0, t); chk("ra_reacc_gap", t - t0, 6); t0 = t;
    chk("ra_at_speed", int'(at_speed[0]), 1);
    chk("ra_busy", int'(busy[0]), 1);
    wait_pulse(0, t); chk("ra_cruise_gap", t - t0, 4);

    // Async reset mid-cruise with run held high.
    reset_pulse();
    t0 = cyc + 1;
    wait_pulse(0, t); chk("post_rst_gap", t - t0, 8);
    chk("post_rst_coils", int'(coils[3:0]), 4'b1100);
    run[0] = 1'b0; wait_idle(0);

    // Random traffic on both channels.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(39) == 0) run[c] = ~run[c];
        if ($urandom_range(29) == 0) dir[c] = 1'($urandom_range(1));
      end
      if ($urandom_range(99) == 0) half_step = ~half_step;
    end
    run = '0;
    for (int c = 0; c < NCH; c++) wait_idle(c);
    chk("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
